regfile_wb_writer: RTL and testbench

//  Write side of the 32x32 general register file; the 32:1 read multiplexers consume its state.

---
 rtl/regfile_wb_writer_if.sv | 41 ++++
 rtl/regfile_wb_writer.sv | 121 ++++++++++++
 tb/tb_regfile_wb_writer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_writer_if.sv
// Write-back request bundle: valid/ready handshake carrying a register write.
// wr_be is present only when RF_BYTE_EN is defined.
interface regfile_wb_writer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
`ifdef RF_BYTE_EN
  logic [3:0]  wr_be;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_be,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_be,
    output wr_ready
  );
`else
  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
`endif
endinterface

// File: rtl/regfile_wb_writer.sv
// Write side of the 32x32 register file: queued write-back, one commit per cycle.
// Optional macro RF_BYTE_EN adds per-entry byte enables.
module regfile_wb_writer #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_VAL  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_writer_if.slave   wr,
  input  logic                 wb_hold_i,
  input  logic                 flush_i,
  output logic [1023:0]        rf_flat_o,
  output logic [31:0]          wr_strobe_o,
  output logic                 busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_q [FIFO_DEPTH];
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [3:0]    be_q   [FIFO_DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   strobe_q, strobe_d;

  logic          ready;
  logic          push;
  logic          commit;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic [3:0]    head_be;
  logic [31:0]   dec;
  logic [3:0]    in_be;

`ifdef RF_BYTE_EN
  assign in_be = wr.wr_be;
`else
  assign in_be = 4'hF;
`endif

  assign ready  = cnt_q < CW'(FIFO_DEPTH);
  assign busy_o = cnt_q != '0;
  assign push   = wr.wr_valid && ready && !flush_i;
  assign commit = busy_o && !wb_hold_i && !flush_i;

  assign wr.wr_ready = ready;

  assign head_addr = addr_q[rptr_q];
  assign head_data = data_q[rptr_q];
  assign head_be   = be_q[rptr_q];
  assign dec       = 32'h1 << head_addr;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    strobe_d = '0;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (commit) begin
        rptr_d   = rptr_q + AW'(1);
        strobe_d = dec;
      end
      cnt_d = cnt_q + CW'(push) - CW'(commit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= wr.wr_addr;
      data_q[wptr_q] <= wr.wr_data;
      be_q[wptr_q]   <= in_be;
    end
  end

  assign wr_strobe_o     = strobe_q;
  assign rf_flat_o[31:0] = 32'h0;

  for (genvar g = 1; g < 32; g++) begin : g_reg
    logic [31:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= RESET_VAL;
      end else if (commit && dec[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (head_be[b]) begin
            r_q[8*b +: 8] <= head_data[8*b +: 8];
          end
        end
      end
    end

    assign rf_flat_o[32*g +: 32] = r_q;
  end

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Directed bench for regfile_wb_writer with a queue-based reference model.
// Define RF_BYTE_EN to also exercise byte-enable merging.
module tb_regfile_wb_writer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic          clk;
  logic          rst;
  logic          hold;
  logic          flush;
  logic [1023:0] rf_flat;
  logic [31:0]   wr_strobe;
  logic          busy;

  int vectors;
  int miscompares;

  regfile_wb_writer_if wif ();

  regfile_wb_writer #(
    .FIFO_DEPTH (DEPTH),
    .RESET_VAL  (RV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wif),
    .wb_hold_i   (hold),
    .flush_i     (flush),
    .rf_flat_o   (rf_flat),
    .wr_strobe_o (wr_strobe),
    .busy_o      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        mq[$];
  ent_t        e;
  logic [31:0] m_regs [32];
  logic [31:0] m_strobe;
  logic        m_acc;
  logic        m_com;
  logic [3:0]  cur_be;

`ifdef RF_BYTE_EN
  assign cur_be = wif.wr_be;
`else
  assign cur_be = 4'hF;
`endif

  // Reference: a queue plus a register array, updated by the rules directly.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 32; i++) m_regs[i] = (i == 0) ? 32'h0 : RV;
      m_strobe = 32'h0;
    end else begin
      m_acc = wif.wr_valid && (mq.size() < DEPTH);
      m_com = (mq.size() > 0) && !hold && !flush;
      if (flush) begin
        mq.delete();
        m_strobe = 32'h0;
      end else begin
        if (m_com) begin
          e = mq.pop_front();
          m_strobe = 32'h1 << e.a;
          if (e.a != 5'd0) begin
            for (int b = 0; b < 4; b++)
              if (e.be[b]) m_regs[e.a][8*b +: 8] = e.d[8*b +: 8];
          end
        end else begin
          m_strobe = 32'h0;
        end
        if (m_acc) mq.push_back('{wif.wr_addr, wif.wr_data, cur_be});
      end
    end
  end

  function automatic logic [1023:0] m_flat();
    logic [1023:0] f;
    for (int i = 0; i < 32; i++) f[32*i +: 32] = m_regs[i];
    return f;
  endfunction

  task automatic chk(input string name, input logic [1023:0] act,
                     input logic [1023:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rf_flat", rf_flat, m_flat());
    chk("wr_strobe", 1024'(wr_strobe), 1024'(m_strobe));
    chk("busy", 1024'(busy), 1024'(mq.size() > 0));
    chk("wr_ready", 1024'(wif.wr_ready), 1024'(mq.size() < DEPTH));
  end

  function automatic logic [31:0] reg_of(input int i);
    return rf_flat[32*i +: 32];
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    int n;
    n = 0;
    wif.wr_valid = 1'b1;
    wif.wr_addr  = a;
    wif.wr_data  = d;
`ifdef RF_BYTE_EN
    wif.wr_be    = be;
`endif
    while (!wif.wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 1024'(0), 1024'(1));
    @(negedge clk);
    wif.wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [1023:0] exp_rst;
  logic [4:0]    s_addr [6];
  logic [31:0]   s_data [6];

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    hold         = 1'b0;
    flush        = 1'b0;
    wif.wr_valid = 1'b0;
    wif.wr_addr  = '0;
    wif.wr_data  = '0;
`ifdef RF_BYTE_EN
    wif.wr_be    = 4'hF;
`endif
    exp_rst = {{31{RV}}, 32'h0};
    #12;
    chk("reset_flat", rf_flat, exp_rst);
    chk("reset_ready", 1024'(wif.wr_ready), 1024'(1));
    chk("reset_busy", 1024'(busy), 1024'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Single write: visible one edge after acceptance.
    push(5'd5, 32'hDEAD_BEEF, 4'hF);
    chk("single_busy", 1024'(busy), 1024'(1));
    chk("single_pre", 1024'(reg_of(5)), 1024'(RV));
    @(negedge clk);
    chk("single_r5", 1024'(reg_of(5)), 1024'(32'hDEAD_BEEF));
    chk("single_strobe", 1024'(wr_strobe), 1024'(32'h20));
    @(negedge clk);
    chk("single_strobe_off", 1024'(wr_strobe), 1024'(0));

    // R0 stays zero, strobe bit 0 still fires.
    push(5'd0, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    chk("r0_value", 1024'(reg_of(0)), 1024'(0));
    chk("r0_strobe", 1024'(wr_strobe), 1024'(32'h1));
    chk("r0_busy", 1024'(busy), 1024'(0));

    // Hold until full, then drain in order while a third push waits.
    hold = 1'b1;
    push(5'd1, 32'hAAAA_0001, 4'hF);
    push(5'd2, 32'hBBBB_0002, 4'hF);
    chk("full_ready", 1024'(wif.wr_ready), 1024'(0));
    wif.wr_valid = 1'b1;
    wif.wr_addr  = 5'd3;
    wif.wr_data  = 32'h3333_0003;
    idle(3);
    chk("full_r3_untouched", 1024'(reg_of(3)), 1024'(RV));
    hold = 1'b0;
    @(negedge clk);
    chk("drain_r1", 1024'(reg_of(1)), 1024'(32'hAAAA_0001));
    chk("drain_r2_pending", 1024'(reg_of(2)), 1024'(RV));
    chk("drain_strobe1", 1024'(wr_strobe), 1024'(32'h2));
    @(negedge clk);
    wif.wr_valid = 1'b0;
    chk("drain_r2", 1024'(reg_of(2)), 1024'(32'hBBBB_0002));
    chk("drain_strobe2", 1024'(wr_strobe), 1024'(32'h4));
    @(negedge clk);
    chk("drain_r3", 1024'(reg_of(3)), 1024'(32'h3333_0003));
    idle(1);

    // Flush discards queued data and a simultaneous push.
    hold = 1'b1;
    push(5'd3, 32'hCCCC_CCCC, 4'hF);
    flush        = 1'b1;
    wif.wr_valid = 1'b1;
    wif.wr_addr  = 5'd9;
    wif.wr_data  = 32'h9999_9999;
    @(negedge clk);
    flush        = 1'b0;
    hold         = 1'b0;
    wif.wr_valid = 1'b0;
    chk("flush_busy", 1024'(busy), 1024'(0));
    chk("flush_strobe", 1024'(wr_strobe), 1024'(0));
    idle(2);
    chk("flush_r3", 1024'(reg_of(3)), 1024'(32'h3333_0003));
    chk("flush_r9", 1024'(reg_of(9)), 1024'(RV));

    // Back-to-back stream: push and commit on the same edges.
    s_addr = '{5'd10, 5'd11, 5'd31, 5'd0, 5'd10, 5'd12};
    s_data = '{32'h0000_0010, 32'h0000_0011, 32'hF00D_0031,
               32'h1234_5678, 32'h0000_1010, 32'h0000_0012};
    wif.wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wif.wr_addr = s_addr[i];
      wif.wr_data = s_data[i];
      @(negedge clk);
    end
    wif.wr_valid = 1'b0;
    idle(3);
    chk("stream_r10", 1024'(reg_of(10)), 1024'(32'h0000_1010));
    chk("stream_r31", 1024'(reg_of(31)), 1024'(32'hF00D_0031));
    chk("stream_r12", 1024'(reg_of(12)), 1024'(32'h0000_0012));

`ifdef RF_BYTE_EN
    push(5'd7, 32'h1122_3344, 4'hF);
    push(5'd7, 32'hAABB_CCDD, 4'b0101);
    @(negedge clk);
    chk("be_r7", 1024'(reg_of(7)), 1024'(32'h11BB_33DD));
    push(5'd7, 32'hFFFF_FFFF, 4'b0000);
    @(negedge clk);
    chk("be_zero_r7", 1024'(reg_of(7)), 1024'(32'h11BB_33DD));
    chk("be_zero_strobe", 1024'(wr_strobe), 1024'(32'h80));
`endif

    // Asynchronous reset in mid-cycle with writes queued.
    hold = 1'b1;
    push(5'd4, 32'h4444_4444, 4'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_flat", rf_flat, exp_rst);
    chk("midrst_ready", 1024'(wif.wr_ready), 1024'(1));
    chk("midrst_busy", 1024'(busy), 1024'(0));
    @(negedge clk);
    rst  = 1'b0;
    hold = 1'b0;
    idle(3);
    chk("post_rst_r4", 1024'(reg_of(4)), 1024'(RV));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
